// File: rtl/reg_bus_pkg.sv
// Shared definitions for the register-map bus bridge and the register map it drives.
package reg_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam int unsigned REG_BUS_AW       = 3;
  localparam int unsigned REG_BUS_DW       = 2;
  localparam int unsigned REG_BUS_NUM_REGS = 2;

endpackage

// File: rtl/reg_bus_bridge_sat_counter.sv
// Saturating up-counter with asynchronous active-low clear.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/reg_bus_bridge.sv
// Valid/ready request/response front end that issues single-cycle READ/WRITE strobes
// to the register map; one transaction in flight, out-of-range addresses return an error.
module reg_bus_bridge
  import reg_bus_pkg::*;
#(
  parameter int unsigned AW       = REG_BUS_AW,
  parameter int unsigned DW       = REG_BUS_DW,
  parameter int unsigned NUM_REGS = REG_BUS_NUM_REGS,
  parameter int unsigned ECW      = 8
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           REQ_VALID,
  output logic           REQ_READY,
  input  logic           REQ_WRITE,
  input  logic [AW-1:0]  REQ_ADDR,
  input  logic [DW-1:0]  REQ_WDATA,
  output logic           RSP_VALID,
  input  logic           RSP_READY,
  output logic [DW-1:0]  RSP_RDATA,
  output logic           RSP_ERR,
  output logic           WRITE,
  output logic           READ,
  output logic [AW-1:0]  ADDR,
  output logic [DW-1:0]  WRITE_DATA,
  input  logic [DW-1:0]  READ_DATA,
  output logic [ECW-1:0] ERR_CNT
);

  state_e        state_q,     state_d;
  logic          req_ready_q, req_ready_d;
  logic          wr_stb_q,    wr_stb_d;
  logic          rd_stb_q,    rd_stb_d;
  logic [AW-1:0] addr_q,      addr_d;
  logic [DW-1:0] wdata_q,     wdata_d;
  logic          err_q,       err_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_err_q,   rsp_err_d;
  logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
  logic          addr_err;

  assign addr_err = ({1'b0, REQ_ADDR} >= (AW+1)'(NUM_REGS));

  // Strobes are decided at accept time so they are registered outputs during ACCESS.
  always_comb begin
    state_d     = state_q;
    req_ready_d = 1'b0;
    wr_stb_d    = 1'b0;
    rd_stb_d    = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    err_d       = err_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    unique case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (REQ_VALID && req_ready_q) begin
          state_d     = ACCESS;
          req_ready_d = 1'b0;
          addr_d      = REQ_ADDR;
          wdata_d     = REQ_WDATA;
          err_d       = addr_err;
          wr_stb_d    = !addr_err && REQ_WRITE;
          rd_stb_d    = !addr_err && !REQ_WRITE;
        end
      end
      ACCESS: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_err_d   = err_q;
        rsp_rdata_d = rd_stb_q ? READ_DATA : '0;
      end
      RESP: begin
        if (RSP_READY) begin
          state_d     = IDLE;
          req_ready_d = 1'b1;
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b0;
      wr_stb_q    <= 1'b0;
      rd_stb_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      wr_stb_q    <= wr_stb_d;
      rd_stb_q    <= rd_stb_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      err_q       <= err_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  sat_counter #(.W(ECW)) u_err_cnt (
    .clk   (CLK),
    .rst_n (RST),
    .inc   ((state_q == ACCESS) && err_q),
    .cnt   (ERR_CNT)
  );

  assign REQ_READY  = req_ready_q;
  assign WRITE      = wr_stb_q;
  assign READ       = rd_stb_q;
  assign ADDR       = addr_q;
  assign WRITE_DATA = wdata_q;
  assign RSP_VALID  = rsp_valid_q;
  assign RSP_ERR    = rsp_err_q;
  assign RSP_RDATA  = rsp_rdata_q;

endmodule
